// File: rtl/iq_phase_scheduler_if.sv
// Requester handshake bundle: host absolute-offset writes and loop phase adjustments.
interface iq_phase_scheduler_if #(
    parameter int unsigned RES = 8
);
    logic           cfg_valid;
    logic [RES-1:0] cfg_offset;
    logic           cfg_ready;
    logic           adj_valid;
    logic [RES-1:0] adj_delta;
    logic           adj_ready;

    // Requester side drives valid/payload and watches ready.
    modport master (
        output cfg_valid, cfg_offset, adj_valid, adj_delta,
        input  cfg_ready, adj_ready
    );

    // Scheduler side grants requests.
    modport slave (
        input  cfg_valid, cfg_offset, adj_valid, adj_delta,
        output cfg_ready, adj_ready
    );
endinterface

// File: rtl/iq_phase_scheduler.sv
// Sequences an I/Q generator: clear, warm-up, sample strobes, and arbitrated phase-offset updates.
module iq_phase_scheduler #(
    parameter int unsigned RES            = 8,
    parameter int unsigned CLK_DIV        = 20,
    parameter int unsigned LATENCY        = 3,
    parameter int unsigned WARMUP_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    iq_phase_scheduler_if.slave req,
    output logic                gen_rst,
    output logic                gen_en,
    output logic                gen_new_sample,
    output logic [RES-1:0]      gen_offset,
    output logic                iq_strobe,
    output logic                busy
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WUP_W = $clog2(WARMUP_SAMPLES + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, WARMUP, RUN} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   div_q;
    logic [WUP_W-1:0]   wup_q;
    logic [LATENCY-1:0] sr_q;
    logic [RES-1:0]     off_q;
    logic               active;
    logic               strobe;
    logic               cfg_grant;
    logic               adj_grant;
    logic               pipe_in;

    // Next state, strobe decode and single-grant arbitration (host before loop).
    always_comb begin
        state_d   = state_q;
        active    = (state_q == WARMUP) || (state_q == RUN);
        strobe    = active && (div_q == DIV_W'(CLK_DIV - 1));
        cfg_grant = 1'b0;
        adj_grant = 1'b0;
        pipe_in   = strobe && (state_q == RUN);
        if (!rst) begin
            if (state_q == IDLE) begin
                cfg_grant = req.cfg_valid;
            end else if (strobe) begin
                cfg_grant = req.cfg_valid;
                adj_grant = req.adj_valid && !req.cfg_valid;
            end
        end
        case (state_q)
            IDLE:    if (start && !stop) state_d = CLEAR;
            CLEAR:   state_d = stop ? IDLE : WARMUP;
            WARMUP: begin
                if (stop)
                    state_d = IDLE;
                else if (strobe && (wup_q == WUP_W'(WARMUP_SAMPLES - 1)))
                    state_d = RUN;
            end
            RUN:     if (stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, divider, warm-up count, offset and output-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            wup_q   <= '0;
            sr_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            if (active && (state_d != IDLE))
                div_q <= strobe ? '0 : div_q + DIV_W'(1);
            else
                div_q <= '0;
            if (state_q == CLEAR)
                wup_q <= '0;
            else if ((state_q == WARMUP) && strobe)
                wup_q <= wup_q + WUP_W'(1);
            if (cfg_grant)
                off_q <= req.cfg_offset;
            else if (adj_grant)
                off_q <= off_q + req.adj_delta;
            // Flushed on leaving RUN so no late output-valid escapes after stop.
            if (state_d != RUN)
                sr_q <= '0;
            else
                sr_q <= (sr_q << 1) | LATENCY'(pipe_in);
        end
    end

    assign req.cfg_ready   = cfg_grant;
    assign req.adj_ready   = adj_grant;
    assign gen_rst         = (state_q == CLEAR);
    assign gen_en          = (state_q != IDLE);
    assign busy            = (state_q != IDLE);
    assign gen_new_sample  = strobe;
    assign gen_offset      = off_q;
    assign iq_strobe       = sr_q[LATENCY-1];
endmodule

// File: tb/tb_iq_phase_scheduler.sv
// Scoreboard bench: a timeline model predicts every output event, a monitor compares DUT events in order.
module tb_iq_phase_scheduler;
    localparam int unsigned RES            = 8;
    localparam int unsigned CLK_DIV        = 20;
    localparam int unsigned LATENCY        = 3;
    localparam int unsigned WARMUP_SAMPLES = 4;
    localparam int unsigned VW             = RES + 7;
    localparam int          D              = int'(CLK_DIV);
    localparam int          L              = int'(LATENCY);
    localparam int          DW             = int'(WARMUP_SAMPLES * CLK_DIV);
    // Bits that are single-cycle pulses: gen_rst, new_sample, iq_strobe, cfg_ready, adj_ready.
    localparam logic [VW-1:0] PULSES = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {RES{1'b0}}};

    typedef struct {
        int            cyc;
        logic [VW-1:0] vec;
    } event_t;

    event_t exp_q[$];

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           gen_rst;
    logic           gen_en;
    logic           gen_new_sample;
    logic [RES-1:0] gen_offset;
    logic           iq_strobe;
    logic           busy;

    iq_phase_scheduler_if #(.RES(RES)) bus ();

    iq_phase_scheduler #(
        .RES(RES), .CLK_DIV(CLK_DIV), .LATENCY(LATENCY), .WARMUP_SAMPLES(WARMUP_SAMPLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .req(bus.slave),
        .gen_rst(gen_rst), .gen_en(gen_en), .gen_new_sample(gen_new_sample),
        .gen_offset(gen_offset), .iq_strobe(iq_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // Requester intent (valid held until the model says it was granted).
    bit             cfg_pend = 1'b0;
    bit             adj_pend = 1'b0;
    logic [RES-1:0] cfg_val  = '0;
    logic [RES-1:0] adj_val  = '0;

    // Timeline model: running flag, cycle of the clear pulse, current offset.
    bit             m_run    = 1'b0;
    int             m_tclr   = 0;
    logic [RES-1:0] m_off    = '0;
    bit             m_strobe = 1'b0;
    logic [VW-1:0]  m_prev   = '0;

    function automatic logic [VW-1:0] observe();
        return {gen_rst, gen_en, busy, gen_new_sample, iq_strobe,
                bus.cfg_ready, bus.adj_ready, gen_offset};
    endfunction

    // Predict this cycle's outputs from elapsed time since clear, then advance the model.
    task automatic model_step(input bit st, input bit sp, input bit r);
        int            k;
        bit            strb;
        bit            iq;
        bit            cg;
        bit            ag;
        logic [VW-1:0] v;
        k    = cyc - m_tclr;
        strb = m_run && (k > 0) && (k % D == 0);
        iq   = m_run && (k - L > DW) && ((k - L) % D == 0);
        cg   = !r && cfg_pend && (!m_run || strb);
        ag   = !r && adj_pend && !cfg_pend && strb;
        v    = {m_run && (k == 0), m_run, m_run, strb, iq, cg, ag, m_off};
        if (v != m_prev || (v & PULSES) != '0)
            exp_q.push_back('{cyc, v});
        m_prev   = v;
        m_strobe = strb;
        if (r) begin
            m_run = 1'b0;
            m_off = '0;
        end else begin
            if (cg) begin
                m_off    = cfg_val;
                cfg_pend = 1'b0;
            end else if (ag) begin
                m_off    = m_off + adj_val;
                adj_pend = 1'b0;
            end
            if (m_run && sp) begin
                m_run = 1'b0;
            end else if (!m_run && st && !sp) begin
                m_run  = 1'b1;
                m_tclr = cyc + 1;
            end
        end
    endtask

    task automatic step(input bit st, input bit sp, input bit r);
        @(posedge clk);
        #1;
        start          = st;
        stop           = sp;
        rst            = r;
        bus.cfg_valid  = cfg_pend;
        bus.cfg_offset = cfg_val;
        bus.adj_valid  = adj_pend;
        bus.adj_delta  = adj_val;
        if (mon_en)
            model_step(st, sp, r);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_cfg();
        int n = 0;
        while (cfg_pend && n < 10 * D) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (cfg_pend) begin
            n_errors++;
            $display("FAIL cfg_grant_timeout: still pending after %0d cycles, required a grant", n);
        end
    endtask

    task automatic wait_adj();
        int n = 0;
        while (adj_pend && n < 10 * D) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (adj_pend) begin
            n_errors++;
            $display("FAIL adj_grant_timeout: still pending after %0d cycles, required a grant", n);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(m_run && (cyc - m_tclr > DW + D)) && n < 4 * DW) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (!m_run) begin
            n_errors++;
            $display("FAIL run_timeout: not running after %0d cycles, required RUN", n);
        end
    endtask

    task automatic wait_strobe();
        int n = 0;
        step(1'b0, 1'b0, 1'b0);
        while (!m_strobe && n < 2 * D) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    // Sample gen_offset one cycle after the last grant and compare to a literal.
    task automatic chk_off(input string name, input logic [RES-1:0] expv);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (gen_offset !== expv) begin
            n_errors++;
            $display("FAIL %s: gen_offset got %h, required %h", name, gen_offset, expv);
        end
    endtask

    // Monitor: every DUT output change or pulse must match the next predicted event.
    initial begin
        logic [VW-1:0] obs;
        logic [VW-1:0] prev;
        event_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                obs = observe();
                if (obs != prev || (obs & PULSES) != '0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_event: cycle %0d got vec %h, required no event", cyc, obs);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.vec !== obs) begin
                            n_errors++;
                            $display("FAIL event: got cycle %0d vec %h, required cycle %0d vec %h",
                                     cyc, obs, e.cyc, e.vec);
                        end
                    end
                end
                prev = obs;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [VW-1:0] obs;
        rst            = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_offset = '0;
        bus.adj_valid  = 1'b0;
        bus.adj_delta  = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL reset_state: outputs got %h, required 0", obs);
        end
        mon_en = 1'b1;
        idle_cycles(2);

        // Host write in IDLE; loop request must wait for a strobe.
        cfg_pend = 1'b1; cfg_val = 8'h80;
        adj_pend = 1'b1; adj_val = 8'h11;
        wait_cfg();
        chk_off("idle_host_write", 8'h80);
        idle_cycles(3);

        // Simultaneous start and stop stays in IDLE.
        step(1'b1, 1'b1, 1'b0);
        idle_cycles(5);

        // Startup, then arbitration: host beats loop on the same strobe.
        step(1'b1, 1'b0, 1'b0);
        wait_run();
        wait_adj();
        cfg_pend = 1'b1; cfg_val = 8'h10;
        wait_cfg();
        cfg_pend = 1'b1; cfg_val = 8'h40;
        adj_pend = 1'b1; adj_val = 8'h05;
        wait_cfg();
        chk_off("arb_host_first", 8'h40);
        wait_adj();
        chk_off("arb_loop_next", 8'h45);

        // Wrap-around in both directions.
        cfg_pend = 1'b1; cfg_val = 8'hFE;
        wait_cfg();
        adj_pend = 1'b1; adj_val = 8'h03;
        wait_adj();
        chk_off("wrap_up", 8'h01);
        adj_pend = 1'b1; adj_val = 8'hFE;
        wait_adj();
        chk_off("wrap_down", 8'hFF);

        // Stop one cycle after a strobe; offset retained across restart.
        wait_strobe();
        step(1'b0, 1'b1, 1'b0);
        idle_cycles(2 * D);
        step(1'b1, 1'b0, 1'b0);
        wait_run();

        // Reset mid-RUN with a loop request pending.
        adj_pend = 1'b1; adj_val = 8'h07;
        step(1'b0, 1'b0, 1'b1);
        idle_cycles(5);
        step(1'b1, 1'b0, 1'b0);
        wait_run();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!cfg_pend && $urandom_range(15) == 0) begin
                cfg_pend = 1'b1;
                cfg_val  = RES'($urandom);
            end
            if (!adj_pend && $urandom_range(5) == 0) begin
                adj_pend = 1'b1;
                adj_val  = RES'($urandom);
            end
            step($urandom_range(40) == 0, $urandom_range(500) == 0, $urandom_range(1500) == 0);
        end

        step(1'b0, 1'b1, 1'b0);
        idle_cycles(10);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_events: %0d predicted events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/iq_phase_scheduler.md
IQ_PHASE_SCHEDULER -- requirements
Module: iq_phase_scheduler

Interface
REQ-001 SHALL have parameter RES, default 8: phase/offset width in bits.
REQ-002 SHALL have parameter CLK_DIV, default 20: clk cycles per sample strobe, minimum 2.
REQ-003 SHALL have parameter LATENCY, default 3: clocks from gen_new_sample to valid generator I/Q output.
REQ-004 SHALL have parameter WARMUP_SAMPLES, default 4: number of strobes discarded after start, minimum 1.
REQ-005 SHALL have ports: clk  in  1  system clock; rst  in  1  reset. One clock domain; rst is synchronous and active-high.
REQ-006 SHALL have ports: start  in  1  begin generation pulse; stop  in  1  halt generation pulse.
REQ-007 SHALL have ports: cfg_valid  in  1; cfg_offset  in  RES  absolute phase offset; cfg_ready  out  1. This is the host requester.
REQ-008 SHALL have ports: adj_valid  in  1; adj_delta  in  RES  signed phase increment; adj_ready  out  1. This is the loop requester.
REQ-009 SHALL have ports: gen_rst  out  1; gen_en  out  1; gen_new_sample  out  1; gen_offset  out  RES. These drive the I/Q generator.
REQ-010 SHALL have ports: iq_strobe  out  1  generator output valid this cycle; busy  out  1  state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, WARMUP and RUN.
- IDLE->CLEAR on start with stop low.
- CLEAR->WARMUP after exactly one cycle.
- WARMUP->RUN on the strobe completing WARMUP_SAMPLES strobes.
- WARMUP/RUN/CLEAR->IDLE on stop, effective next cycle.
REQ-012 SHALL ignore start outside IDLE. Simultaneous start and stop in IDLE SHALL leave the FSM in IDLE.
REQ-013 SHALL assert gen_rst for exactly the one CLEAR cycle.
REQ-014 SHALL drive gen_en high in CLEAR, WARMUP and RUN, and low in IDLE.
REQ-015 SHALL run the divider counter 0..CLK_DIV-1 only in WARMUP/RUN, holding it at 0 otherwise.
- The strobe fires when count==CLK_DIV-1; the counter then wraps to 0.
- The first strobe is the CLK_DIV-th cycle of WARMUP.
REQ-016 SHALL drive gen_new_sample as a one-cycle pulse equal to the strobe, never asserted in IDLE or CLEAR.
REQ-017 SHALL keep a warmup counter that is cleared in CLEAR and increments on each WARMUP strobe; the strobe reaching WARMUP_SAMPLES enters RUN.
REQ-018 SHALL produce iq_strobe from a LATENCY-stage shift register.
- Its input is gen_new_sample AND state==RUN.
- The register is cleared whenever the state is not RUN, so no iq_strobe appears after stop.
REQ-019 SHALL hold the offset register off_q and drive gen_offset = off_q directly (registered, no combinational path from inputs).
REQ-020 SHALL grant host updates in IDLE on any cycle: cfg_ready = cfg_valid, and off_q <= cfg_offset the same edge.
REQ-021 SHALL grant at most one update per strobe cycle in WARMUP/RUN.
- Host has strict priority: if cfg_valid, off_q <= cfg_offset and cfg_ready=1.
- Else if adj_valid, off_q <= off_q + adj_delta modulo 2^RES and adj_ready=1.
REQ-022 SHALL keep cfg_ready and adj_ready low on all other cycles. adj_ready SHALL never assert in IDLE or CLEAR.
REQ-023 SHALL complete a transfer only when valid and ready are both high; an ungranted requester keeps valid high and is served at a later strobe.
REQ-024 SHALL make an offset written on a strobe edge visible on gen_offset from the next cycle, so it applies to the following gen_new_sample.
REQ-025 SHALL wrap addition modulo 2^RES with no saturation. The sign of adj_delta only matters through two's-complement wrap.
REQ-026 SHALL retain off_q across stop/start; only rst clears it.

Reset
REQ-027 SHALL, on rst high at a clock edge, set all of the following, overriding all other inputs including mid-RUN:
- state IDLE; off_q, divider, warmup counter and shift register 0.
- Outputs gen_rst, gen_en, gen_new_sample, gen_offset, cfg_ready, adj_ready, iq_strobe and busy all 0.
REQ-028 SHALL hold pending requests unserved while rst is high; requesters keep valid asserted.

Verification
REQ-029 SHALL cover startup with defaults: start pulse -> gen_rst high 1 cycle; first gen_new_sample 20 cycles later; strobes every 20 cycles; RUN entered at the 4th strobe; first iq_strobe 3 cycles after the 5th strobe.
REQ-030 SHALL cover arbitration: in RUN, off_q=0x10, cfg_offset=0x40 and adj_delta=0x05 both valid -> at strobe N cfg_ready=1 and gen_offset=0x40; at strobe N+1 adj_ready=1 and gen_offset=0x45.
REQ-031 SHALL cover wrap-around: off_q=0xFE, adj_delta=0x03 -> gen_offset=0x01. Then off_q=0x01, adj_delta=0xFE (-2) -> gen_offset=0xFF.
REQ-032 SHALL cover IDLE host write: cfg_valid with cfg_offset=0x80 in IDLE -> cfg_ready same cycle, gen_offset=0x80 next cycle; adj_valid in IDLE -> adj_ready stays 0.
REQ-033 SHALL cover stop mid-RUN: stop asserted 1 cycle after a strobe -> busy, gen_en and iq_strobe low the next cycle; no further iq_strobe; off_q retained.
REQ-034 SHALL cover rst mid-RUN with adj_valid high -> all outputs 0 next cycle; start with start and stop asserted together -> FSM stays in IDLE.
